// File: rtl/count_bcd_display_pkg.sv
// Shared constants for the BCD count display: converter state encoding,
// active-low 7-segment patterns (gfedcba) and small datapath helpers.
package count_bcd_display_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [11:0] add3_digits(input logic [11:0] acc);
    logic [11:0] res;
    res = acc;
    for (int d = 0; d < 3; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end else begin
        res[4*d +: 4] = acc[4*d +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/count_bcd_display_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter. Re-converts whenever the
// sampled count differs from the last converted one, or after a clear.
module bin2bcd_seq
  import count_bcd_display_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  count_in,
  output logic [11:0] bcd_out,
  output logic        bcd_valid
);

  conv_state_e state_r;
  logic [7:0]  last_smp_r;
  logic [7:0]  bin_r;
  logic [11:0] acc_r;
  logic [2:0]  step_r;
  logic        force_r;
  logic [11:0] acc_adj_s;
  logic [11:0] acc_shift_s;

  // One shift/add-3 step of the accumulator.
  always_comb begin
    acc_adj_s   = add3_digits(acc_r);
    acc_shift_s = {acc_adj_s[10:0], bin_r[7]};
  end

  // Converter FSM and datapath.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= IDLE;
      bcd_out    <= 12'h000;
      bcd_valid  <= 1'b0;
      last_smp_r <= 8'd0;
      force_r    <= 1'b1;
      bin_r      <= 8'd0;
      acc_r      <= 12'h000;
      step_r     <= 3'd0;
    end else begin
      bcd_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (force_r || (count_in != last_smp_r)) begin
            last_smp_r <= count_in;
            bin_r      <= count_in;
            acc_r      <= 12'h000;
            step_r     <= 3'd0;
            force_r    <= 1'b0;
            state_r    <= CONV;
          end
        end
        CONV: begin
          acc_r  <= acc_shift_s;
          bin_r  <= {bin_r[6:0], 1'b0};
          step_r <= step_r + 3'd1;
          if (step_r == 3'd7) begin
            bcd_out   <= acc_shift_s;
            bcd_valid <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/count_bcd_display.sv
// Converts the upstream 8-bit count to BCD and drives a 4-digit multiplexed
// common-anode 7-segment display; digit 3 is strobed but always blank.
module count_bcd_display
  import count_bcd_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LEAD_BLANK  = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  count_in,
  output logic [11:0] bcd_out,
  output logic        bcd_valid,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] refresh_cnt_r;
  logic [1:0]       idx_r;
  logic             hund_blank_s;
  logic             tens_blank_s;
  logic [6:0]       seg_next_s;
  logic [3:0]       an_next_s;

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .clr       (clr),
    .count_in  (count_in),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid)
  );

  // Leading-zero blanking and segment lookup for the currently selected digit.
  always_comb begin
    hund_blank_s = LEAD_BLANK && (bcd_out[11:8] == 4'd0);
    tens_blank_s = LEAD_BLANK && (bcd_out[11:4] == 8'd0);
    an_next_s    = ~(4'b0001 << idx_r);
    case (idx_r)
      2'd0:    seg_next_s = seg_pattern(bcd_out[3:0]);
      2'd1:    seg_next_s = tens_blank_s ? SEG_BLANK : seg_pattern(bcd_out[7:4]);
      2'd2:    seg_next_s = hund_blank_s ? SEG_BLANK : seg_pattern(bcd_out[11:8]);
      2'd3:    seg_next_s = SEG_BLANK;
      default: seg_next_s = SEG_BLANK;
    endcase
  end

  // Refresh timer, digit index and registered display outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      refresh_cnt_r <= '0;
      idx_r         <= 2'd0;
      seg_n         <= SEG_BLANK;
      an_n          <= 4'hF;
    end else begin
      if (refresh_cnt_r == CNT_MAX) begin
        refresh_cnt_r <= '0;
        idx_r         <= idx_r + 2'd1;
      end else begin
        refresh_cnt_r <= refresh_cnt_r + CNT_ONE;
      end
      seg_n <= seg_next_s;
      an_n  <= an_next_s;
    end
  end

endmodule
